mem_arbiter: RTL and testbench

Two-master arbiter sharing the single physical memory request port between the MMU (port 0) and a second master such as a loader or DMA (port 1). Both sides use the codebase's pulse handshake: a one-cycle `request_enable` carrying mode, addr, wdata and wstrb, answered by a one-cycle `response_enable` carrying data. The block sits between the MMU's physical port and the memory controller. It serves one transaction at a time with round-robin fairness.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_slot.sv | 36 +++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types, constants and round-robin pick for mem_arbiter
package mem_arbiter_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef enum logic [1:0] {IDLE, WAIT_RESP, RESPOND} memarb_state_t;
  typedef logic memarb_port_t;

  localparam logic [31:0] MEMARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

  function automatic memarb_port_t memarb_pick(input logic v0, input logic v1,
                                               input memarb_port_t last);
    if (v0 && v1) return ~last;
    else if (v0)  return 1'b0;
    else          return 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_slot.sv
// rtl/mem_arbiter_slot.sv - one-deep pending request slot; pulses while full are dropped
module mem_arbiter_slot (
  input  logic        clk,
  input  logic        rstn,
  input  logic        request_enable,
  input  logic        req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic        clear,
  output logic        valid,
  output logic        mode,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      mode  <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      wstrb <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (request_enable && !valid) begin
      valid <= 1'b1;
      mode  <= req_mode;
      addr  <= req_addr;
      wdata <= req_wdata;
      wstrb <= req_wstrb;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter onto one memory request port
// Optional downstream hang detection: MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        p0_request_enable,
  input  logic        p0_req_mode,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  input  logic [3:0]  p0_req_wstrb,
  input  logic        p1_request_enable,
  input  logic        p1_req_mode,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  input  logic [3:0]  p1_req_wstrb,
  output logic        p0_response_enable,
  output logic [31:0] p0_resp_data,
  output logic        p1_response_enable,
  output logic [31:0] p1_resp_data,
  output logic        request_enable,
  output logic        req_mode,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        response_enable,
  input  logic [31:0] resp_data,
  output logic        timeout_error
);

  memarb_state_t state, state_nxt;
  memarb_port_t  grant_id, grant_nxt, last_grant, last_nxt, winner, rsp_tgt;
  logic          v0, v1, m0, m1, clear0, clear1, expired, rsp_fire, req_en_nxt;
  logic [31:0]   a0, a1, w0, w1, rsp_val;
  logic [3:0]    s0, s1;

  mem_arbiter_slot u_slot0 (
    .clk(clk), .rstn(rstn), .request_enable(p0_request_enable), .req_mode(p0_req_mode),
    .req_addr(p0_req_addr), .req_wdata(p0_req_wdata), .req_wstrb(p0_req_wstrb),
    .clear(clear0), .valid(v0), .mode(m0), .addr(a0), .wdata(w0), .wstrb(s0)
  );

  mem_arbiter_slot u_slot1 (
    .clk(clk), .rstn(rstn), .request_enable(p1_request_enable), .req_mode(p1_req_mode),
    .req_addr(p1_req_addr), .req_wdata(p1_req_wdata), .req_wstrb(p1_req_wstrb),
    .clear(clear1), .valid(v1), .mode(m1), .addr(a1), .wdata(w1), .wstrb(s1)
  );

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        timeout_q;

  assign expired       = (state == WAIT_RESP) && !response_enable &&
                         (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign timeout_error = timeout_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt  <= (state == WAIT_RESP) ? wait_cnt + 16'd1 : 16'd0;
      timeout_q <= timeout_q | expired;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT_CYCLES);
  assign expired        = 1'b0;
  assign timeout_error  = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_id;
    last_nxt   = last_grant;
    req_en_nxt = 1'b0;
    rsp_fire   = 1'b0;
    rsp_tgt    = grant_id;
    rsp_val    = resp_data;
    winner     = memarb_pick(v0, v1, last_grant);
    case (state)
      IDLE: begin
        if (v0 || v1) begin
          grant_nxt = winner;
          last_nxt  = winner;
          // once memory is known hung, pending slots are answered locally
          if (timeout_error) begin
            rsp_fire  = 1'b1;
            rsp_tgt   = winner;
            rsp_val   = MEMARB_TIMEOUT_DATA;
            state_nxt = RESPOND;
          end else begin
            req_en_nxt = 1'b1;
            state_nxt  = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (response_enable) begin
          rsp_fire  = 1'b1;
          state_nxt = RESPOND;
        end else if (expired) begin
          rsp_fire  = 1'b1;
          rsp_val   = MEMARB_TIMEOUT_DATA;
          state_nxt = RESPOND;
        end
      end
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    clear0 = rsp_fire && (rsp_tgt == 1'b0);
    clear1 = rsp_fire && (rsp_tgt == 1'b1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state              <= IDLE;
      grant_id           <= 1'b0;
      last_grant         <= 1'b1;
      request_enable     <= 1'b0;
      req_mode           <= 1'b0;
      req_addr           <= '0;
      req_wdata          <= '0;
      req_wstrb          <= '0;
      p0_response_enable <= 1'b0;
      p1_response_enable <= 1'b0;
      p0_resp_data       <= '0;
      p1_resp_data       <= '0;
    end else begin
      state              <= state_nxt;
      grant_id           <= grant_nxt;
      last_grant         <= last_nxt;
      request_enable     <= req_en_nxt;
      p0_response_enable <= clear0;
      p1_response_enable <= clear1;
      if (req_en_nxt) begin
        req_mode  <= winner ? m1 : m0;
        req_addr  <= winner ? a1 : a0;
        req_wdata <= winner ? w1 : w0;
        req_wstrb <= winner ? s1 : s0;
      end
      if (clear0) p0_resp_data <= rsp_val;
      if (clear1) p1_resp_data <= rsp_val;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (timeout case under MEM_ARBITER_TIMEOUT_EN)
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        p0_request_enable, p1_request_enable, p0_req_mode, p1_req_mode;
  logic [31:0] p0_req_addr, p1_req_addr, p0_req_wdata, p1_req_wdata;
  logic [3:0]  p0_req_wstrb, p1_req_wstrb;
  logic        p0_response_enable, p1_response_enable;
  logic [31:0] p0_resp_data, p1_resp_data;
  logic        request_enable, req_mode;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;
  logic        timeout_error;

  typedef struct {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          lat;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_p0[$];
  logic [31:0] exp_p1[$];
  int total = 0, bad = 0;
  int cyc = 0, fire_cyc = 0, last_req_cyc = 0, last_rsp0_cyc = 0;
  int rcnt = 0, manual_cnt = 0, manual_seen = 0;
  logic [31:0] rval = '0;

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn),
    .p0_request_enable(p0_request_enable), .p0_req_mode(p0_req_mode),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_wstrb(p0_req_wstrb),
    .p1_request_enable(p1_request_enable), .p1_req_mode(p1_req_mode),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_wstrb(p1_req_wstrb),
    .p0_response_enable(p0_response_enable), .p0_resp_data(p0_resp_data),
    .p1_response_enable(p1_response_enable), .p1_resp_data(p1_resp_data),
    .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .response_enable(response_enable), .resp_data(resp_data),
    .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // downstream memory model: checks each request against the scoreboard and answers it
  always @(negedge clk) begin
    req_t e;
    if (!rstn) begin
      response_enable = 1'b0;
      rcnt = 0;
    end else begin
      response_enable = 1'b0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          response_enable = 1'b1;
          resp_data = rval;
        end
      end
      if (manual_cnt != manual_seen) begin
        manual_seen = manual_cnt;
        response_enable = 1'b1;
        resp_data = 32'h5A5A_5A5A;
      end
      if (request_enable) begin
        last_req_cyc = cyc;
        if (exp_req.size() == 0) check("req_unexpected", 1, 0);
        else begin
          e = exp_req.pop_front();
          check("req_mode", req_mode, e.mode);
          check("req_addr", req_addr, e.addr);
          check("req_wdata", req_wdata, e.wdata);
          check("req_wstrb", req_wstrb, e.wstrb);
          if (e.lat > 0) begin
            rcnt = e.lat;
            rval = e.rdata;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (p0_response_enable) begin
      last_rsp0_cyc = cyc;
      if (exp_p0.size() == 0) check("p0_rsp_unexpected", 1, 0);
      else check("p0_rsp_data", p0_resp_data, exp_p0.pop_front());
    end
    if (p1_response_enable) begin
      if (exp_p1.size() == 0) check("p1_rsp_unexpected", 1, 0);
      else check("p1_rsp_data", p1_resp_data, exp_p1.pop_front());
    end
  end

  task automatic ld0(input logic m, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    p0_req_mode = m; p0_req_addr = a; p0_req_wdata = w; p0_req_wstrb = s;
  endtask

  task automatic ld1(input logic m, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    p1_req_mode = m; p1_req_addr = a; p1_req_wdata = w; p1_req_wstrb = s;
  endtask

  task automatic expect_req(input logic m, input logic [31:0] a, input logic [31:0] w,
                            input logic [3:0] s, input logic [31:0] rd, input int lat);
    req_t e;
    e.mode = m; e.addr = a; e.wdata = w; e.wstrb = s; e.rdata = rd; e.lat = lat;
    exp_req.push_back(e);
  endtask

  task automatic fire(input logic e0, input logic e1);
    fire_cyc = cyc;
    p0_request_enable = e0;
    p1_request_enable = e1;
    @(negedge clk);
    p0_request_enable = 1'b0;
    p1_request_enable = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_req.size() + exp_p0.size() + exp_p1.size()) != 0; i++)
      @(negedge clk);
    check("drain", exp_req.size() + exp_p0.size() + exp_p1.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_en"}, request_enable, 0);
    check({tag, "_req_addr"}, req_addr, 0);
    check({tag, "_req_misc"}, {req_mode, req_wdata, req_wstrb}, 0);
    check({tag, "_rsp_en"}, {p0_response_enable, p1_response_enable}, 0);
    check({tag, "_p0_data"}, p0_resp_data, 0);
    check({tag, "_p1_data"}, p1_resp_data, 0);
    check({tag, "_tout"}, timeout_error, 0);
  endtask

  initial begin
    rstn = 1'b0;
    p0_request_enable = 1'b0; p1_request_enable = 1'b0;
    ld0(MEMREQ_READ, 0, 0, 0);
    ld1(MEMREQ_READ, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // tie just after reset: port 0 first
    ld0(MEMREQ_READ, 32'h0000_0100, 0, 4'hF);
    ld1(MEMREQ_READ, 32'h0000_0200, 0, 4'hF);
    expect_req(MEMREQ_READ, 32'h0000_0100, 0, 4'hF, 32'hA0A0_0001, 2);
    expect_req(MEMREQ_READ, 32'h0000_0200, 0, 4'hF, 32'hB0B0_0002, 4);
    exp_p0.push_back(32'hA0A0_0001);
    exp_p1.push_back(32'hB0B0_0002);
    fire(1, 1);
    drain();

    // single read and request latency
    ld0(MEMREQ_READ, 32'h0000_1000, 0, 4'hF);
    expect_req(MEMREQ_READ, 32'h0000_1000, 0, 4'hF, 32'h1234_5678, 3);
    exp_p0.push_back(32'h1234_5678);
    fire(1, 0);
    drain();
    check("req_latency", last_req_cyc - fire_cyc, 2);

    // tie after port 0 was last: port 1 first
    ld0(MEMREQ_READ, 32'h0000_0300, 0, 4'hF);
    ld1(MEMREQ_READ, 32'h0000_0400, 0, 4'hF);
    expect_req(MEMREQ_READ, 32'h0000_0400, 0, 4'hF, 32'hC0C0_0004, 1);
    expect_req(MEMREQ_READ, 32'h0000_0300, 0, 4'hF, 32'hC0C0_0003, 3);
    exp_p1.push_back(32'hC0C0_0004);
    exp_p0.push_back(32'hC0C0_0003);
    fire(1, 1);
    drain();

    // repeated pulses while pending are dropped
    ld1(MEMREQ_READ, 32'h0000_0500, 0, 4'hF);
    expect_req(MEMREQ_READ, 32'h0000_0500, 0, 4'hF, 32'h0000_0555, 5);
    exp_p1.push_back(32'h0000_0555);
    fire(0, 1);
    ld1(MEMREQ_READ, 32'h0000_0600, 0, 4'hF);
    fire(0, 1);
    ld1(MEMREQ_READ, 32'h0000_0700, 0, 4'hF);
    fire(0, 1);
    drain();

    // write from port 1
    ld1(MEMREQ_WRITE, 32'h0000_0800, 32'hCAFE_F00D, 4'b0011);
    expect_req(MEMREQ_WRITE, 32'h0000_0800, 32'hCAFE_F00D, 4'b0011, 32'h0000_0000, 1);
    exp_p1.push_back(32'h0000_0000);
    fire(0, 1);
    drain();

    // reset while waiting on memory; later response must be ignored
    ld0(MEMREQ_READ, 32'h0000_0900, 0, 4'hF);
    expect_req(MEMREQ_READ, 32'h0000_0900, 0, 4'hF, 0, 0);
    fire(1, 0);
    repeat (4) @(negedge clk);
    check("rst_mid_granted", exp_req.size(), 0);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    manual_cnt++;
    repeat (6) @(negedge clk);
    check_outputs_zero("rst_mid");

`ifdef MEM_ARBITER_TIMEOUT_EN
    ld0(MEMREQ_READ, 32'h0000_0A00, 0, 4'hF);
    expect_req(MEMREQ_READ, 32'h0000_0A00, 0, 4'hF, 0, 0);
    exp_p0.push_back(32'hDEAD_BEEF);
    fire(1, 0);
    drain();
    check("tout_latency", last_rsp0_cyc - last_req_cyc, 8);
    check("tout_flag", timeout_error, 1);
    ld1(MEMREQ_READ, 32'h0000_0B00, 0, 4'hF);
    exp_p1.push_back(32'hDEAD_BEEF);
    fire(0, 1);
    drain();
    check("tout_sticky", timeout_error, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
